// File: rtl/multicycle_core_pkg.sv
// Shared types and instruction-field layout for the multi-cycle integer core.
package core_pkg;

  typedef enum logic [5:0] {
    OP_MOVE   = 6'd1,
    OP_NEG    = 6'd2,
    OP_ADD    = 6'd3,
    OP_ADDI   = 6'd4,
    OP_SUB    = 6'd5,
    OP_SUBI   = 6'd6,
    OP_SRL    = 6'd7,
    OP_SLL    = 6'd8,
    OP_LI     = 6'd9,
    OP_LW     = 6'd10,
    OP_SW     = 6'd11,
    OP_BEQ    = 6'd12,
    OP_J      = 6'd13,
    OP_READI  = 6'd41,
    OP_PRINTI = 6'd42,
    OP_HALT   = 6'd63
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_IO_WAIT, S_WB, S_HALT
  } state_t;

  localparam logic [5:0] HALT_OPC = 6'd63;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RA_LO  = 21;
  localparam int RB_LO  = 16;
  localparam int RC_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int LI_HI  = 20;
  localparam int LI_LO  = 5;

  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      OP_MOVE, OP_NEG, OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_SRL, OP_SLL,
      OP_LI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_READI, OP_PRINTI, HALT_OPC: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic writes_reg(input logic [5:0] op);
    case (op)
      OP_MOVE, OP_NEG, OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_SRL, OP_SLL,
      OP_LI, OP_LW, OP_READI: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_core_if.sv
// Loader, byte-stream and status signals of the core, grouped for the top level.
interface multicycle_core_if #(
  parameter int IMEM_DEPTH = 1024
);
  localparam int IAW = $clog2(IMEM_DEPTH);

  logic           LOAD_WE;
  logic [IAW-1:0] LOAD_ADDR;
  logic [31:0]    LOAD_DATA;
  logic           START;
  logic [7:0]     IN_DATA;
  logic           IN_VALID;
  logic           IN_READY;
  logic [7:0]     OUT_DATA;
  logic           OUT_VALID;
  logic           OUT_READY;
  logic           BUSY;
  logic           HALTED;
  logic           ERROR;
  logic [IAW-1:0] PC;

  modport master (
    output LOAD_WE, LOAD_ADDR, LOAD_DATA, START, IN_DATA, IN_VALID, OUT_READY,
    input  IN_READY, OUT_DATA, OUT_VALID, BUSY, HALTED, ERROR, PC
  );

  modport slave (
    input  LOAD_WE, LOAD_ADDR, LOAD_DATA, START, IN_DATA, IN_VALID, OUT_READY,
    output IN_READY, OUT_DATA, OUT_VALID, BUSY, HALTED, ERROR, PC
  );
endinterface

// File: rtl/multicycle_core_alu.sv
// Combinational ALU: result for the current opcode plus an a==b flag for BEQ.
module core_alu
  import core_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] res_o,
  output logic        eq_o
);
  always_comb begin
    res_o = '0;
    case (op_i)
      OP_MOVE:                      res_o = a_i;
      OP_NEG:                       res_o = -a_i;
      OP_ADD, OP_ADDI, OP_LW, OP_SW: res_o = a_i + b_i;
      OP_SUB, OP_SUBI:              res_o = a_i - b_i;
      OP_SRL:                       res_o = a_i >> b_i[4:0];
      OP_SLL:                       res_o = a_i << b_i[4:0];
      OP_LI:                        res_o = b_i;
      default:                      res_o = '0;
    endcase
  end

  assign eq_o = (a_i == b_i);
endmodule

// File: rtl/multicycle_core.sv
// Five-phase multi-cycle integer core with separate instruction/data memories
// and handshaked byte I/O.
module multicycle_core
  import core_pkg::*;
#(
  parameter int IMEM_DEPTH = 1024,
  parameter int DMEM_DEPTH = 1024,
  parameter int NREG       = 32,
  parameter int SP_REG     = 28,
  parameter int SP_INIT    = DMEM_DEPTH / 2
) (
  input logic              CLK,
  input logic              RST_N,
  multicycle_core_if.slave bus
);
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);
  localparam int RAW = $clog2(NREG);
  localparam logic [RAW-1:0] SP_IDX = RAW'(SP_REG);

  state_t         state_q, state_d;
  logic [31:0]    imem_q [IMEM_DEPTH];
  logic [31:0]    dmem_q [DMEM_DEPTH];
  logic [31:0]    rf_q   [NREG];
  logic [31:0]    ir_q, res_q, ld_q;
  logic [IAW-1:0] pc_q;
  logic           err_q, out_valid_q;
  logic [7:0]     out_data_q;

  logic [5:0]     op;
  logic [RAW-1:0] ra_idx, rb_idx, rc_idx;
  logic [31:0]    imm_sx, li_zx, ra_val, rb_val, rc_val, alu_a, alu_b, alu_res, wb_val;
  logic           alu_eq, busy, start_go, load_go, rf_we, dmem_we, in_ready, io_done;

  assign op     = ir_q[OP_HI:OP_LO];
  assign ra_idx = ir_q[RA_LO +: RAW];
  assign rb_idx = ir_q[RB_LO +: RAW];
  assign rc_idx = ir_q[RC_LO +: RAW];
  assign imm_sx = {{16{ir_q[IMM_HI]}}, ir_q[IMM_HI:IMM_LO]};
  assign li_zx  = {16'h0, ir_q[LI_HI:LI_LO]};
  assign ra_val = rf_q[ra_idx];
  assign rb_val = rf_q[rb_idx];
  assign rc_val = rf_q[rc_idx];
  assign wb_val = (op == OP_LW) ? ld_q : res_q;

  // BEQ compares ra against rb; every other opcode operates on rb.
  always_comb begin
    alu_a = (op == OP_BEQ) ? ra_val : rb_val;
    case (op)
      OP_ADD, OP_SUB: alu_b = rc_val;
      OP_BEQ:         alu_b = rb_val;
      OP_LI:          alu_b = li_zx;
      default:        alu_b = imm_sx;
    endcase
  end

  core_alu u_alu (
    .op_i  (op),
    .a_i   (alu_a),
    .b_i   (alu_b),
    .res_o (alu_res),
    .eq_o  (alu_eq)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  assign io_done = (op == OP_READI) ? bus.IN_VALID : bus.OUT_READY;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HALT: if (bus.START) state_d = S_FETCH;
      S_FETCH:        state_d = S_DECODE;
      S_DECODE:       state_d = S_EXEC;
      S_EXEC: begin
        if (op == HALT_OPC || !is_legal(op))     state_d = S_HALT;
        else if (op == OP_LW || op == OP_SW)     state_d = S_MEM;
        else if (op == OP_READI || op == OP_PRINTI) state_d = S_IO_WAIT;
        else                                     state_d = S_WB;
      end
      S_MEM:          state_d = S_WB;
      S_IO_WAIT:      if (io_done) state_d = S_WB;
      S_WB:           state_d = S_FETCH;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = !(state_q == S_IDLE || state_q == S_HALT);
    in_ready = (state_q == S_IO_WAIT) && (op == OP_READI);
    rf_we    = (state_q == S_WB) && writes_reg(op);
    dmem_we  = (state_q == S_MEM) && (op == OP_SW);
  end

  assign start_go = bus.START && !busy;
  assign load_go  = bus.LOAD_WE && !busy;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q        <= '0;
      err_q       <= 1'b0;
      ir_q        <= '0;
      res_q       <= '0;
      ld_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (start_go) begin
        pc_q  <= '0;
        err_q <= 1'b0;
      end
      if (state_q == S_FETCH) begin
        pc_q <= pc_q + IAW'(1);
        ir_q <= imem_q[pc_q];
      end
      // pc already points past the branch here, so adding imm yields pc+1+imm.
      if (state_q == S_EXEC) begin
        res_q <= alu_res;
        if (op == OP_BEQ && alu_eq) pc_q <= pc_q + imm_sx[IAW-1:0];
        if (op == OP_J)             pc_q <= imm_sx[IAW-1:0];
        if (!is_legal(op))          err_q <= 1'b1;
        if (op == OP_PRINTI) begin
          out_valid_q <= 1'b1;
          out_data_q  <= ra_val[7:0];
        end
      end
      if (state_q == S_MEM) ld_q <= dmem_q[res_q[DAW-1:0]];
      if (state_q == S_IO_WAIT) begin
        if (op == OP_READI && bus.IN_VALID)   res_q <= {24'h0, bus.IN_DATA};
        if (op == OP_PRINTI && bus.OUT_READY) out_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      if (rf_we)    rf_q[ra_idx] <= wb_val;
      if (start_go) rf_q[SP_IDX] <= 32'(SP_INIT);
    end
  end

  always_ff @(posedge CLK) begin
    if (load_go) imem_q[bus.LOAD_ADDR] <= bus.LOAD_DATA;
    if (dmem_we) dmem_q[res_q[DAW-1:0]] <= ra_val;
  end

  assign bus.IN_READY  = in_ready;
  assign bus.OUT_DATA  = out_data_q;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.BUSY      = busy;
  assign bus.HALTED    = (state_q == S_HALT);
  assign bus.ERROR     = err_q;
  assign bus.PC        = pc_q;
endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: directed programs plus random straight-line programs
// checked against an instruction-level reference model.
module tb_multicycle_core;
  localparam int IMEM_DEPTH = 1024;
  localparam int DMEM_DEPTH = 1024;
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam logic [5:0] MOVE = 6'd1, NEG = 6'd2, ADD = 6'd3, ADDI = 6'd4, SUB = 6'd5,
                         SUBI = 6'd6, SRL = 6'd7, SLL = 6'd8, LI = 6'd9, LW = 6'd10,
                         SW = 6'd11, BEQ = 6'd12, J = 6'd13, READI = 6'd41,
                         PRINTI = 6'd42, HALT = 6'd63;
  localparam logic [31:0] HALT_W = {HALT, 26'd0};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  multicycle_core_if #(.IMEM_DEPTH(IMEM_DEPTH)) bus ();

  multicycle_core #(
    .IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH), .NREG(32),
    .SP_REG(28), .SP_INIT(DMEM_DEPTH / 2)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_xfer  = 0;

  logic [31:0] mreg [32];
  logic [31:0] mimem [IMEM_DEPTH];
  logic [31:0] mdmem [int];
  logic [7:0]  min_q [$];
  logic [7:0]  mout_q [$];
  logic [31:0] prog [$];
  logic [5:0]  alu_ops [8] = '{MOVE, NEG, ADD, ADDI, SUB, SUBI, SRL, SLL};

  always @(posedge clk) if (bus.OUT_VALID && bus.OUT_READY) n_xfer <= n_xfer + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [5:0] op, input int ra, input int rb, input int low16);
    return {op, 5'(ra), 5'(rb), 16'(low16)};
  endfunction

  function automatic logic [31:0] enc_li(input int ra, input int v);
    return {LI, 5'(ra), 16'(v), 5'd0};
  endfunction

  // Reference model: executes mimem from pc 0 at instruction level and
  // accumulates the documented per-instruction latencies.
  task automatic model_exec(output int cyc, output bit err);
    int pc, ra, rb, rc;
    logic [31:0] ins, imm, a;
    logic [5:0] op;
    bit done;
    mreg[28] = 32'd512;
    pc = 0; err = 0; cyc = 1; done = 0;
    for (int s = 0; s < 5000 && !done; s++) begin
      ins = mimem[pc];
      op = ins[31:26]; ra = ins[25:21]; rb = ins[20:16]; rc = ins[15:11];
      imm = {{16{ins[15]}}, ins[15:0]};
      pc = (pc + 1) % IMEM_DEPTH;
      cyc += 4;
      case (op)
        MOVE:   mreg[ra] = mreg[rb];
        NEG:    mreg[ra] = 32'd0 - mreg[rb];
        ADD:    mreg[ra] = mreg[rb] + mreg[rc];
        ADDI:   mreg[ra] = mreg[rb] + imm;
        SUB:    mreg[ra] = mreg[rb] - mreg[rc];
        SUBI:   mreg[ra] = mreg[rb] - imm;
        SRL:    mreg[ra] = mreg[rb] >> imm[4:0];
        SLL:    mreg[ra] = mreg[rb] << imm[4:0];
        LI:     mreg[ra] = {16'h0, ins[20:5]};
        LW: begin
          a = (mreg[rb] + imm) % DMEM_DEPTH;
          mreg[ra] = mdmem.exists(int'(a)) ? mdmem[int'(a)] : 32'd0;
          cyc += 1;
        end
        SW: begin
          a = (mreg[rb] + imm) % DMEM_DEPTH;
          mdmem[int'(a)] = mreg[ra];
          cyc += 1;
        end
        BEQ:    if (mreg[ra] == mreg[rb]) pc = int'((32'(pc) + imm) % IMEM_DEPTH);
        J:      pc = int'(imm % IMEM_DEPTH);
        READI:  mreg[ra] = (min_q.size() > 0) ? {24'h0, min_q.pop_front()} : 32'd0;
        PRINTI: mout_q.push_back(mreg[ra][7:0]);
        HALT: begin cyc -= 1; done = 1; end
        default: begin err = 1; cyc -= 1; done = 1; end
      endcase
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
  endtask

  task automatic load_word(input int addr, input logic [31:0] data);
    @(negedge clk);
    bus.LOAD_WE = 1'b1; bus.LOAD_ADDR = IAW'(addr); bus.LOAD_DATA = data;
    mimem[addr] = data;
    @(negedge clk);
    bus.LOAD_WE = 1'b0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < prog.size(); i++) begin
      @(negedge clk);
      bus.LOAD_WE = 1'b1; bus.LOAD_ADDR = IAW'(i); bus.LOAD_DATA = prog[i];
      mimem[i] = prog[i];
    end
    @(negedge clk);
    bus.LOAD_WE = 1'b0;
  endtask

  task automatic start_pulse();
    @(negedge clk); bus.START = 1'b1;
    @(posedge clk);
    @(negedge clk); bus.START = 1'b0;
  endtask

  task automatic wait_halt(input int cyc0, output int cyc);
    cyc = cyc0;
    while (!bus.HALTED && cyc < 5000) begin
      @(posedge clk); cyc++; #1;
    end
    check_eq("halt_reached", bus.HALTED, 1);
  endtask

  task automatic run_prog(output int cyc);
    start_pulse();
    wait_halt(1, cyc);
  endtask

  task automatic compare_model(input string tag, input bit chk_cyc, input int cyc);
    int mc;
    bit me;
    model_exec(mc, me);
    for (int i = 0; i < 8; i++) check_eq($sformatf("%s_r%0d", tag, i), dut.rf_q[i], mreg[i]);
    check_eq({tag, "_r28"}, dut.rf_q[28], mreg[28]);
    check_eq({tag, "_err"}, bus.ERROR, me);
    if (chk_cyc) check_eq({tag, "_cycles"}, cyc, mc);
  endtask

  task automatic gen_random_prog();
    int st [$];
    prog.delete();
    for (int k = 0; k < 16; k++) begin
      int sel, ra, rb, imm, a;
      sel = $urandom_range(0, 10);
      ra  = $urandom_range(1, 7);
      rb  = $urandom_range(0, 7);
      imm = $urandom_range(0, 65535);
      if (sel == 9 && st.size() == 0) sel = 10;
      if (sel < 8) prog.push_back(enc(alu_ops[sel], ra, rb, imm));
      else if (sel == 8) prog.push_back(enc_li(ra, imm));
      else if (sel == 9) begin
        a = st[$urandom_range(0, st.size() - 1)] ^ (1024 * $urandom_range(0, 1));
        prog.push_back(enc(LW, ra, 0, a));
      end else begin
        a = $urandom_range(0, 2047);
        st.push_back(a);
        prog.push_back(enc(SW, $urandom_range(0, 7), 0, a));
      end
    end
    prog.push_back(HALT_W);
  endtask

  initial begin
    int cyc, n0, bad;
    logic [7:0] seen;
    bus.LOAD_WE = 0; bus.LOAD_ADDR = '0; bus.LOAD_DATA = '0; bus.START = 0;
    bus.IN_DATA = '0; bus.IN_VALID = 0; bus.OUT_READY = 0;
    #1 rst_n = 1'b0;
    #2;
    check_eq("rst_busy", bus.BUSY, 0);
    check_eq("rst_halted", bus.HALTED, 0);
    check_eq("rst_error", bus.ERROR, 0);
    check_eq("rst_pc", 32'(bus.PC), 0);
    check_eq("rst_in_ready", bus.IN_READY, 0);
    check_eq("rst_out_valid", bus.OUT_VALID, 0);
    check_eq("rst_out_data", 32'(bus.OUT_DATA), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // LI / ADDI negative immediate, HALT timing
    do_reset();
    prog = '{enc_li(1, 5), enc(ADDI, 2, 1, -7), HALT_W};
    load_prog();
    run_prog(cyc);
    check_eq("t1_cycles", cyc, 12);
    check_eq("t1_r2", dut.rf_q[2], 32'hFFFF_FFFE);
    check_eq("t1_error", bus.ERROR, 0);
    compare_model("t1", 1, cyc);

    // store at DMEM_DEPTH+3 wraps to 3, load back
    do_reset();
    mdmem.delete();
    prog = '{enc_li(1, 'h1234), enc_li(3, 1024), enc(SW, 1, 3, 3), enc(LW, 4, 0, 3), HALT_W};
    load_prog();
    run_prog(cyc);
    check_eq("wrap_r4", dut.rf_q[4], 32'h1234);
    check_eq("wrap_dmem3", dut.dmem_q[3], 32'h1234);
    check_eq("wrap_cycles", cyc, 22);
    compare_model("wrap", 1, cyc);

    // BEQ loop: equal/unequal operands, negative offset, 3 iterations
    do_reset();
    prog = '{enc_li(1, 0), enc_li(2, 3), enc(ADDI, 1, 1, 1), enc(BEQ, 1, 2, 1),
             enc(BEQ, 0, 0, -3), HALT_W};
    load_prog();
    run_prog(cyc);
    check_eq("beq_r1", dut.rf_q[1], 3);
    check_eq("beq_cycles", cyc, 44);
    compare_model("beq", 1, cyc);

    // random straight-line programs
    for (int p = 0; p < 4; p++) begin
      do_reset();
      mdmem.delete();
      gen_random_prog();
      load_prog();
      run_prog(cyc);
      compare_model($sformatf("rnd%0d", p), 1, cyc);
    end

    // PRINTI with OUT_READY held low
    do_reset();
    mout_q.delete();
    prog = '{enc_li(1, 'h5A), enc(PRINTI, 1, 0, 0), HALT_W};
    load_prog();
    n0 = n_xfer;
    start_pulse();
    for (int i = 0; i < 20 && !bus.OUT_VALID; i++) begin @(posedge clk); #1; end
    check_eq("print_valid", bus.OUT_VALID, 1);
    seen = bus.OUT_DATA;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.OUT_VALID !== 1'b1 || bus.OUT_DATA !== seen) bad++;
    end
    check_eq("print_stable", bad, 0);
    @(negedge clk); bus.OUT_READY = 1'b1;
    @(posedge clk); #1;
    check_eq("print_valid_drop", bus.OUT_VALID, 0);
    @(negedge clk); bus.OUT_READY = 1'b0;
    wait_halt(0, cyc);
    check_eq("print_xfers", n_xfer - n0, 1);
    compare_model("print", 0, cyc);
    check_eq("print_data", 32'(seen), 32'(mout_q.size() > 0 ? mout_q[0] : 8'h00));

    // READI with IN_VALID delayed
    do_reset();
    min_q.delete();
    min_q.push_back(8'hA5);
    prog = '{enc(READI, 3, 0, 0), HALT_W};
    load_prog();
    start_pulse();
    for (int i = 0; i < 20 && !bus.IN_READY; i++) begin @(posedge clk); #1; end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.IN_READY !== 1'b1) bad++;
    end
    check_eq("read_ready_held", bad, 0);
    @(negedge clk); bus.IN_VALID = 1'b1; bus.IN_DATA = 8'hA5;
    @(posedge clk); #1;
    check_eq("read_ready_drop", bus.IN_READY, 0);
    @(negedge clk); bus.IN_VALID = 1'b0; bus.IN_DATA = 8'h00;
    wait_halt(0, cyc);
    check_eq("read_r3", dut.rf_q[3], 32'h0000_00A5);
    compare_model("read", 0, cyc);

    // illegal opcode, then START from HALT
    do_reset();
    prog = '{enc_li(28, 7), {6'h20, 26'd0}};
    load_prog();
    run_prog(cyc);
    check_eq("ill_error", bus.ERROR, 1);
    check_eq("ill_r28", dut.rf_q[28], 7);
    compare_model("ill", 1, cyc);
    start_pulse();
    check_eq("restart_pc", 32'(bus.PC), 0);
    check_eq("restart_error", bus.ERROR, 0);
    check_eq("restart_sp", dut.rf_q[28], 512);
    check_eq("restart_busy", bus.BUSY, 1);
    wait_halt(0, cyc);

    // LOAD_WE and START while busy are ignored
    do_reset();
    prog.delete();
    for (int i = 0; i < 10; i++) prog.push_back(enc(ADDI, 1, 1, 1));
    prog.push_back(HALT_W);
    load_prog();
    load_word(100, 32'hDEAD_BEEF);
    start_pulse();
    repeat (3) @(negedge clk);
    bus.LOAD_WE = 1'b1; bus.LOAD_ADDR = IAW'(100); bus.LOAD_DATA = 32'h1234_5678; bus.START = 1'b1;
    @(negedge clk);
    bus.LOAD_ADDR = IAW'(5); bus.LOAD_DATA = HALT_W;
    @(negedge clk);
    bus.LOAD_WE = 1'b0; bus.START = 1'b0;
    wait_halt(0, cyc);
    check_eq("busy_load_100", dut.imem_q[100], 32'hDEAD_BEEF);
    check_eq("busy_load_5", dut.imem_q[5], enc(ADDI, 1, 1, 1));
    check_eq("busy_r1", dut.rf_q[1], 10);

    // asynchronous reset during PRINTI wait, then a normal run
    do_reset();
    prog = '{enc_li(1, 'h33), enc(PRINTI, 1, 0, 0), HALT_W};
    load_prog();
    start_pulse();
    for (int i = 0; i < 20 && !bus.OUT_VALID; i++) begin @(posedge clk); #1; end
    check_eq("arst_pre_valid", bus.OUT_VALID, 1);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", bus.OUT_VALID, 0);
    check_eq("arst_busy", bus.BUSY, 0);
    check_eq("arst_halted", bus.HALTED, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    prog = '{enc_li(1, 5), enc(ADDI, 2, 1, -7), HALT_W};
    load_prog();
    run_prog(cyc);
    check_eq("arst_rerun_cycles", cyc, 12);
    check_eq("arst_rerun_r2", dut.rf_q[2], 32'hFFFF_FFFE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
